idu_issue_scoreboard: RTL and testbench
=======================================

Name: idu_issue_scoreboard

Overview:
- Parametrised decode-to-execute issue stage that succeeds the purely combinational IDU.
- Holds one decoded instruction in a register and issues it to EXU over a valid/ready handshake.
- Blocks issue on read-after-write hazards using per-GPR pending-write counters.
- Counters increment at issue and decrement when any of RET_N retire channels reports the destination; supports multiple in-flight writers and pipeline flush.

Parameters:
BITS_W, 64, PC/data width
INST_W, 32, instruction width
GPR_W, 5, register index width; NREG = 2**GPR_W (4 gives RV32E)
CTRL_W, 64, width of opaque decoded control bundle (ALU/jump/mem/WB flags)
RET_N, 2, number of retire/writeback channels
CNT_W, 2, pending counter width per register; max in-flight writers per reg = 2**CNT_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill held instruction (branch redirect/trap)
in_valid  in  1  decoded instruction available
in_ready  out  1  stage can accept
in_pc  in  BITS_W  instruction PC
in_inst  in  INST_W  raw instruction
in_rs1, in_rs2, in_rd  in  GPR_W each  register indices
in_use_rs1, in_use_rs2, in_wr_rd  in  1 each  operand-read / GPR-write flags
in_ctrl  in  CTRL_W  decoded control bundle
out_valid  out  1  instruction issuable
out_ready  in  1  EXU accepts
out_pc, out_inst, out_rs1, out_rs2, out_rd, out_wr_rd, out_ctrl  out  as inputs  held payload
ret_valid  in  RET_N  retire channel k valid
ret_rd  in  RET_N*GPR_W  retire channel k destination (slice k)
stall_raw  out  1  held instruction valid but blocked by hazard
sb_busy  out  1  any counter non-zero

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. Reset sets all counters to 0, hold_valid to 0, all out_* payload to 0, stall_raw and sb_busy to 0. Reset mid-operation discards the held instruction and all pending counts.
- Hazard is computed combinationally from the registered counters and the held payload: (use_rs1 & rs1!=0 & cnt[rs1]!=0) | (use_rs2 & rs2!=0 & cnt[rs2]!=0) | (wr_rd & rd!=0 & cnt[rd]==MAX).
- out_valid = hold_valid & !hazard & !flush.
- stall_raw = hold_valid & hazard.
- fire = out_valid & out_ready.
- in_ready = !flush & (!hold_valid | fire). An accepted instruction loads the hold register the next cycle, giving zero-bubble back-to-back issue.
- Flush: hold_valid <= 0, no fire, no counter increment, input not accepted. Instructions already issued downstream still retire normally.
- Counter update per register r: inc = fire & out_wr_rd & out_rd==r & r!=0; dec = count of k with ret_valid[k] & ret_rd[k]==r. cnt_next = cnt + inc - dec, applied simultaneously. Equal inc and dec leave cnt unchanged.
- Release latency: a retire in cycle T unblocks a dependent instruction at T+1 (no retire bypass).
- Retire with rd==0 is ignored.
- Underflow (dec > cnt + inc) is a protocol error: a simulation assertion fires and the counter clamps at 0.
- Saturation: a writer whose rd counter is already at MAX is held; the counter never wraps.
- Payload is stable while out_valid & !out_ready (AXI-style hold). out_valid may drop without fire only on flush or on a hazard raised by an intervening issue. EXU must not depend on out_valid staying high.
- Every issued instruction with wr_rd & rd!=0 retires exactly once, either by writeback or as a kill report on a retire channel.

Decomposition:
- Shared package idu_pkg: NREG, cnt_t, ctrl bundle typedef (struct matching CTRL_W), retire channel struct {valid, rd}.
- Sub-module idu_pending_cnt: the NREG x CNT_W counter array with inc/multi-dec/clamp logic and any-busy reduction. The top holds the payload register and handshake.

Test Plan:
1. Independent stream: add x1; add x2; add x3 with out_ready=1 -> fires on 3 consecutive cycles, stall_raw=0 throughout, cnt[1..3]=1.
2. RAW: issue rd=5, then rs1=5 -> stall_raw=1, out_valid=0; ret rd=5 at cycle T -> out_valid=1 at T+1, cnt[5]=0 then re-incremented if writer.
3. Multiple writers (CNT_W=2): two writes to x7 issued, cnt[7]=2; retire one -> reader of x7 still stalled; retire second -> issues next cycle.
4. Saturation (CNT_W=1): two writers to x3 -> second held, stall_raw=1, until ret rd=3, then issues; cnt[3] stays 1.
5. Flush with held instruction and out_ready=1 -> no fire, counter unchanged, in_ready=0 that cycle, out_valid=0 next cycle.
6. Dual retire both rd=4 with cnt[4]=2 -> cnt[4]=0, sb_busy falls; retire rd=0 -> no change; rst asserted mid-stall -> all counts 0, out_valid=0.

Source files
------------

// File: rtl/idu_pkg.sv
// idu_pkg: shared sizes, types and helpers for the issue scoreboard
package idu_pkg;
  localparam int GPR_W_DEF = 5;
  localparam int NREG = 2 ** GPR_W_DEF;
  localparam int CNT_W_DEF = 2;
  localparam int CTRL_W_DEF = 64;
  typedef logic [CNT_W_DEF-1:0] cnt_t;
  typedef struct packed {
    logic [3:0]  alu_op;
    logic        jump;
    logic        branch;
    logic        mem_rd;
    logic        mem_wr;
    logic        wb;
    logic [54:0] rsvd;
  } ctrl_t;
  typedef struct packed {
    logic                 valid;
    logic [GPR_W_DEF-1:0] rd;
  } ret_ch_t;
  function automatic int nreg_of(input int gpr_w);
    return 2 ** gpr_w;
  endfunction
endpackage

// File: rtl/idu_pending_cnt.sv
// idu_pending_cnt: per-register pending-write counters with single increment, multi-retire decrement and zero clamp
module idu_pending_cnt
  import idu_pkg::*;
#(
  parameter int GPR_W = 5,
  parameter int CNT_W = 2,
  parameter int RET_N = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              inc_en,
  input  logic [GPR_W-1:0]                  inc_rd,
  input  logic [RET_N-1:0]                  ret_valid,
  input  logic [RET_N*GPR_W-1:0]            ret_rd,
  output logic [nreg_of(GPR_W)*CNT_W-1:0]   cnt,
  output logic                              busy
);
  localparam int NREG_P = nreg_of(GPR_W);
  localparam int SW = CNT_W + $clog2(RET_N + 1) + 1;
  logic [CNT_W-1:0] cnt_q [NREG_P];
  logic [SW-1:0]    sum   [NREG_P];
  logic [SW-1:0]    dec   [NREG_P];
  always_comb begin
    for (int r = 0; r < NREG_P; r++) begin
      dec[r] = '0;
      for (int k = 0; k < RET_N; k++)
        dec[r] = dec[r] + SW'(ret_valid[k] && r != 0 && ret_rd[k*GPR_W +: GPR_W] == GPR_W'(r));
      sum[r] = SW'(cnt_q[r]) + SW'(inc_en && r != 0 && inc_rd == GPR_W'(r));
    end
  end
  always_ff @(posedge clk)
    for (int r = 0; r < NREG_P; r++)
      cnt_q[r] <= rst ? '0 : (sum[r] < dec[r]) ? '0 : CNT_W'(sum[r] - dec[r]);
  always_ff @(posedge clk)
    for (int r = 0; r < NREG_P; r++)
      if (!rst) assert (sum[r] >= dec[r]) else $error("idu_pending_cnt: retire underflow on x%0d", r);
  always_comb begin
    cnt = '0;
    for (int r = 0; r < NREG_P; r++) cnt[r*CNT_W +: CNT_W] = cnt_q[r];
  end
  assign busy = |cnt;
endmodule

// File: rtl/idu_issue_scoreboard.sv
// idu_issue_scoreboard: single-entry issue register with valid/ready handshake blocked by per-GPR pending-write hazards
module idu_issue_scoreboard
  import idu_pkg::*;
#(
  parameter int BITS_W = 64,
  parameter int INST_W = 32,
  parameter int GPR_W  = 5,
  parameter int CTRL_W = 64,
  parameter int RET_N  = 2,
  parameter int CNT_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BITS_W-1:0]      in_pc,
  input  logic [INST_W-1:0]      in_inst,
  input  logic [GPR_W-1:0]       in_rs1,
  input  logic [GPR_W-1:0]       in_rs2,
  input  logic [GPR_W-1:0]       in_rd,
  input  logic                   in_use_rs1,
  input  logic                   in_use_rs2,
  input  logic                   in_wr_rd,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS_W-1:0]      out_pc,
  output logic [INST_W-1:0]      out_inst,
  output logic [GPR_W-1:0]       out_rs1,
  output logic [GPR_W-1:0]       out_rs2,
  output logic [GPR_W-1:0]       out_rd,
  output logic                   out_wr_rd,
  output logic [CTRL_W-1:0]      out_ctrl,
  input  logic [RET_N-1:0]       ret_valid,
  input  logic [RET_N*GPR_W-1:0] ret_rd,
  output logic                   stall_raw,
  output logic                   sb_busy
);
  localparam int NREG_P = nreg_of(GPR_W);
  logic                      hold_valid, use_rs1_q, use_rs2_q, hazard, fire;
  logic [NREG_P*CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]          c_rs1, c_rs2, c_rd;
  assign c_rs1 = cnt[out_rs1*CNT_W +: CNT_W];
  assign c_rs2 = cnt[out_rs2*CNT_W +: CNT_W];
  assign c_rd  = cnt[out_rd*CNT_W +: CNT_W];
  assign hazard = (use_rs1_q && out_rs1 != '0 && c_rs1 != '0) ||
                  (use_rs2_q && out_rs2 != '0 && c_rs2 != '0) ||
                  (out_wr_rd && out_rd != '0 && c_rd == '1);
  assign out_valid = hold_valid && !hazard && !flush;
  assign stall_raw = hold_valid && hazard;
  assign fire      = out_valid && out_ready;
  assign in_ready  = !flush && (!hold_valid || fire);
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      use_rs1_q  <= 1'b0;
      use_rs2_q  <= 1'b0;
      out_pc     <= '0;
      out_inst   <= '0;
      out_rs1    <= '0;
      out_rs2    <= '0;
      out_rd     <= '0;
      out_wr_rd  <= 1'b0;
      out_ctrl   <= '0;
    end else begin
      hold_valid <= flush ? 1'b0 : in_ready ? in_valid : hold_valid;
      if (in_ready && in_valid) begin
        use_rs1_q <= in_use_rs1;
        use_rs2_q <= in_use_rs2;
        out_pc    <= in_pc;
        out_inst  <= in_inst;
        out_rs1   <= in_rs1;
        out_rs2   <= in_rs2;
        out_rd    <= in_rd;
        out_wr_rd <= in_wr_rd;
        out_ctrl  <= in_ctrl;
      end
    end
  end
  idu_pending_cnt #(.GPR_W(GPR_W), .CNT_W(CNT_W), .RET_N(RET_N)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (fire && out_wr_rd),
    .inc_rd    (out_rd),
    .ret_valid (ret_valid),
    .ret_rd    (ret_rd),
    .cnt       (cnt),
    .busy      (sb_busy)
  );
endmodule

// File: tb/tb_idu_issue_scoreboard.sv
// tb_idu_issue_scoreboard: directed stimulus checked against a per-cycle behavioural model plus literal expectations
module tb_idu_issue_scoreboard;
  localparam int BITS_W = 64, INST_W = 32, GPR_W = 5, CTRL_W = 64, RET_N = 2, CNT_W = 2;
  localparam int NREG = 32, MAX = 3;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready, stall_raw, sb_busy;
  logic in_use_rs1, in_use_rs2, in_wr_rd, out_wr_rd;
  logic [BITS_W-1:0] in_pc, out_pc, pc_ctr;
  logic [INST_W-1:0] in_inst, out_inst;
  logic [GPR_W-1:0] in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [RET_N-1:0] ret_valid;
  logic [RET_N*GPR_W-1:0] ret_rd;
  int n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;
  idu_issue_scoreboard #(.BITS_W(BITS_W), .INST_W(INST_W), .GPR_W(GPR_W), .CTRL_W(CTRL_W), .RET_N(RET_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wr_rd(in_wr_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_wr_rd(out_wr_rd), .out_ctrl(out_ctrl),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .stall_raw(stall_raw), .sb_busy(sb_busy)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [63:0] dcnt(input int r);
    return 64'(dut.cnt[r*CNT_W +: CNT_W]);
  endfunction
  int mcnt [NREG];
  bit mhv, m_u1, m_u2, m_wr;
  logic [BITS_W-1:0] m_pc;
  logic [INST_W-1:0] m_inst;
  logic [GPR_W-1:0] m_rs1, m_rs2, m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  always @(negedge clk) begin
    bit haz, ov, fr, busy;
    int dec;
    logic [63:0] ecnt;
    haz = (m_u1 && m_rs1 != 0 && mcnt[m_rs1] > 0) || (m_u2 && m_rs2 != 0 && mcnt[m_rs2] > 0) ||
          (m_wr && m_rd != 0 && mcnt[m_rd] == MAX);
    ov = mhv && !haz && !flush;
    fr = ov && out_ready;
    busy = 0;
    ecnt = '0;
    for (int r = 0; r < NREG; r++) begin
      busy = busy || mcnt[r] != 0;
      ecnt[r*CNT_W +: CNT_W] = CNT_W'(mcnt[r]);
    end
    chk("m_out_valid", 64'(out_valid), 64'(ov));
    chk("m_stall_raw", 64'(stall_raw), 64'(mhv && haz));
    chk("m_in_ready", 64'(in_ready), 64'(!flush && (!mhv || fr)));
    chk("m_sb_busy", 64'(sb_busy), 64'(busy));
    chk("m_cnt", 64'(dut.cnt), ecnt);
    if (mhv) begin
      chk("m_out_pc", out_pc, m_pc);
      chk("m_out_inst", 64'(out_inst), 64'(m_inst));
      chk("m_out_regs", 64'({out_rs1, out_rs2, out_rd, out_wr_rd}), 64'({m_rs1, m_rs2, m_rd, m_wr}));
      chk("m_out_ctrl", out_ctrl, m_ctrl);
    end
    if (rst) begin
      mhv = 0;
      m_u1 = 0; m_u2 = 0; m_wr = 0;
      for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        dec = 0;
        for (int k = 0; k < RET_N; k++) if (ret_valid[k] && ret_rd[k*GPR_W +: GPR_W] == GPR_W'(r)) dec++;
        mcnt[r] = mcnt[r] + ((fr && m_wr && m_rd == GPR_W'(r) && r != 0) ? 1 : 0) - dec;
        if (mcnt[r] < 0 || r == 0) mcnt[r] = 0;
      end
      if (flush) mhv = 0;
      else if (!mhv || fr) begin
        mhv = in_valid;
        if (in_valid) begin
          m_pc = in_pc; m_inst = in_inst; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd;
          m_u1 = in_use_rs1; m_u2 = in_use_rs2; m_wr = in_wr_rd; m_ctrl = in_ctrl;
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic w);
    pc_ctr = pc_ctr + 4;
    in_valid = 1; in_pc = pc_ctr; in_inst = $urandom; in_ctrl = {$urandom, $urandom};
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_use_rs1 = u1; in_use_rs2 = u2; in_wr_rd = w;
  endtask
  task automatic idle;
    in_valid = 0;
  endtask
  task automatic ret(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1);
    ret_valid = v;
    ret_rd = {r1, r0};
  endtask
  initial begin
    rst = 1; flush = 0; out_ready = 0; pc_ctr = 64'h1000;
    in_valid = 0; in_pc = 0; in_inst = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_use_rs1 = 0; in_use_rs2 = 0; in_wr_rd = 0; in_ctrl = 0; ret(0, 0, 0);
    tick; tick;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_stall", 64'(stall_raw), 0);
    chk("rst_busy", 64'(sb_busy), 0);
    chk("rst_out_pc", out_pc, 0);
    tick;
    rst = 0; out_ready = 1;
    issue(0, 0, 1, 0, 0, 1); tick;
    issue(0, 0, 2, 0, 0, 1);
    @(negedge clk); chk("t1_fire_x1", 64'({out_valid, out_rd}), 64'({1'b1, 5'd1})); tick;
    issue(0, 0, 3, 0, 0, 1);
    @(negedge clk); chk("t1_fire_x2", 64'({out_valid, stall_raw, out_rd}), 64'({2'b10, 5'd2})); tick;
    idle;
    @(negedge clk); chk("t1_fire_x3", 64'({out_valid, stall_raw, out_rd}), 64'({2'b10, 5'd3})); tick;
    @(negedge clk);
    chk("t1_cnt123", {dcnt(1)[7:0], dcnt(2)[7:0], dcnt(3)[7:0]}, 64'h010101);
    chk("t1_busy", 64'(sb_busy), 1);
    tick;
    ret(2'b11, 1, 2); tick;
    ret(2'b01, 3, 0); tick;
    ret(0, 0, 0);
    @(negedge clk); chk("t1_busy_clear", 64'(sb_busy), 0); tick;
    issue(0, 0, 5, 0, 0, 1); tick;
    issue(5, 0, 6, 1, 0, 1); tick;
    idle;
    @(negedge clk); chk("t2_raw_stall", 64'({stall_raw, out_valid}), 64'(2'b10)); tick;
    ret(2'b01, 5, 0);
    @(negedge clk); chk("t2_no_bypass", 64'(stall_raw), 1); tick;
    ret(0, 0, 0);
    @(negedge clk); chk("t2_release", 64'({out_valid, out_rd}), 64'({1'b1, 5'd6})); tick;
    @(negedge clk); chk("t2_cnt56", {dcnt(5)[7:0], dcnt(6)[7:0]}, 64'h0001); tick;
    ret(2'b01, 6, 0); tick;
    ret(0, 0, 0);
    issue(0, 0, 7, 0, 0, 1); tick;
    issue(0, 0, 7, 0, 0, 1); tick;
    issue(7, 0, 8, 1, 0, 0); tick;
    idle;
    @(negedge clk); chk("t3_cnt7_two", dcnt(7), 2); chk("t3_stall", 64'(stall_raw), 1); tick;
    ret(2'b01, 7, 0); tick;
    ret(0, 0, 0);
    @(negedge clk); chk("t3_still_stall", 64'({stall_raw, dcnt(7)[1:0]}), 64'(3'b101)); tick;
    ret(2'b10, 0, 7);
    @(negedge clk); chk("t3_stall_last", 64'(stall_raw), 1); tick;
    ret(0, 0, 0);
    @(negedge clk); chk("t3_issue", 64'({out_valid, out_rs1}), 64'({1'b1, 5'd7})); tick;
    issue(0, 0, 3, 0, 0, 1); tick;
    issue(0, 0, 3, 0, 0, 1); tick;
    issue(0, 0, 3, 0, 0, 1); tick;
    issue(0, 0, 3, 0, 0, 1); tick;
    idle;
    @(negedge clk); chk("t4_sat_stall", 64'({stall_raw, out_valid}), 64'(2'b10)); chk("t4_cnt3_max", dcnt(3), 3); tick;
    ret(2'b01, 3, 0);
    @(negedge clk); chk("t4_sat_hold", 64'(stall_raw), 1); tick;
    ret(0, 0, 0);
    @(negedge clk); chk("t4_sat_issue", 64'(out_valid), 1); tick;
    @(negedge clk); chk("t4_cnt3_again", dcnt(3), 3); tick;
    ret(2'b11, 3, 3); tick;
    ret(2'b01, 3, 0); tick;
    ret(0, 0, 0);
    @(negedge clk); chk("t4_busy_clear", 64'(sb_busy), 0); tick;
    out_ready = 0;
    issue(0, 0, 9, 0, 0, 1); tick;
    idle;
    @(negedge clk); chk("t5_held", 64'({out_valid, out_rd}), 64'({1'b1, 5'd9})); tick;
    @(negedge clk); chk("t5_held_pc", out_pc, pc_ctr); tick;
    flush = 1; out_ready = 1; issue(0, 0, 10, 0, 0, 1);
    @(negedge clk); chk("t5_flush", 64'({out_valid, in_ready}), 0); tick;
    flush = 0; idle;
    @(negedge clk);
    chk("t5_after_flush", 64'({out_valid, stall_raw, sb_busy}), 0);
    chk("t5_cnt9", dcnt(9), 0);
    tick;
    issue(0, 0, 4, 0, 0, 1); tick;
    issue(0, 0, 4, 0, 0, 1); tick;
    idle; tick;
    @(negedge clk); chk("t6_cnt4_two", dcnt(4), 2); tick;
    ret(2'b11, 4, 4);
    @(negedge clk); chk("t6_busy_before", 64'(sb_busy), 1); tick;
    ret(0, 0, 0);
    @(negedge clk); chk("t6_dual_ret", 64'({dcnt(4)[1:0], sb_busy}), 0); tick;
    issue(0, 0, 4, 0, 0, 1); tick;
    idle; tick;
    ret(2'b11, 0, 0); tick;
    ret(0, 0, 0);
    @(negedge clk); chk("t6_ret_x0", 64'({dcnt(4)[1:0], sb_busy}), 64'(3'b011)); tick;
    issue(4, 0, 0, 1, 0, 0); tick;
    idle;
    @(negedge clk); chk("t6_stall_pre_rst", 64'(stall_raw), 1); tick;
    rst = 1; tick;
    rst = 0;
    @(negedge clk);
    chk("t6_rst_clear", 64'({out_valid, stall_raw, sb_busy}), 0);
    chk("t6_rst_cnt4", dcnt(4), 0);
    tick;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
